mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller for the 5-stage RISC-V pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register and consumes the EX/MEM outputs. It performs loads and stores on the data memory over a req/ack handshake, and stalls the upstream pipeline while an access is outstanding. It also resolves branches and owns the MEM/WB register contents.

## Interface
Parameters:
- XLEN, 64, datapath and address width
- TIMEOUT, 16, watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- exm_alu_result  input  XLEN  memory address or ALU result
- exm_writedata  input  XLEN  store data
- exm_adderout  input  XLEN  branch target
- exm_rd  input  5  destination register
- exm_branch, exm_zero, exm_memread, exm_memtoreg, exm_memwrite, exm_regwrite  input  1 each  EX/MEM control
- dm_req  output  1  memory request, registered
- dm_we  output  1  1 = store, 0 = load
- dm_addr  output  XLEN  access address
- dm_wdata  output  XLEN  store data
- dm_ack  input  1  one-cycle completion pulse
- dm_rdata  input  XLEN  load data, valid with dm_ack
- stall  output  1  hold PC, IF/ID, ID/EX and EX/MEM
- pcsrc  output  1  branch taken; also the flush request
- branch_target  output  XLEN  equals exm_adderout
- wb_readdata, wb_alu_result  output  XLEN  MEM/WB data
- wb_rd  output  5  MEM/WB destination register
- wb_memtoreg, wb_regwrite  output  1  MEM/WB control
- dm_err  output  1  sticky timeout flag

## Operation
- acc = exm_memread | exm_memwrite. If both are set, the access is a store.
- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ when acc.
  - REQ → DONE on dm_ack.
  - DONE → IDLE unconditionally.
- REQ state:
  - dm_req = 1.
  - dm_addr = exm_alu_result, dm_wdata = exm_writedata, dm_we = exm_memwrite.
  - These are registered on entry to REQ and held stable until ack.
  - On dm_ack, dm_rdata is captured into an internal read buffer.
- stall = acc & (state != DONE). This is combinational.
- dm_ack in IDLE or DONE is ignored.
- MEM/WB update rule (every edge):
  - stall = 0: load the EX/MEM values. wb_readdata takes the read buffer for loads and 0 otherwise.
  - stall = 1: load a bubble (all MEM/WB fields 0).
- pcsrc = exm_branch & exm_zero, combinational. It is independent of stall; branches never access memory.
- No alignment check is performed. The address is passed through unmodified.

## Timing
- Reset (asynchronous, reset = 0): state IDLE. All outputs 0, including dm_req, dm_err, the read buffer and all MEM/WB fields. An in-flight request is dropped immediately.
- Non-memory instruction: passes to MEM/WB at the next edge, zero stall cycles.
- Access with zero-wait memory (ack in the first REQ cycle):
  - Cycle 0: IDLE, stall = 1.
  - Cycle 1: REQ, ack arrives.
  - Cycle 2: DONE, stall = 0.
  - The instruction lands in MEM/WB at the end of cycle 2: two stall cycles.
- Each extra wait cycle before dm_ack adds one stall cycle.
- Back-to-back accesses: after DONE → IDLE, the next access begins; there is no overlap.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter increments in REQ and clears on leaving REQ.
  - If it reaches TIMEOUT without dm_ack, go to DONE with read buffer = 0 and set dm_err. dm_err stays set until reset.
  - A dm_ack arriving on the same cycle as the timeout wins: the data is valid and dm_err is not set.
- MEM_TIMEOUT_EN undefined: no counter. REQ waits indefinitely and dm_err is tied to 0.

## Structure
- Package mem_stage_pkg holds:
  - the state enum (IDLE, REQ, DONE);
  - the XLEN default;
  - a typedef for the MEM/WB bundle struct.
- One sub-module, memwb_reg: the MEM/WB register with a bubble-insert input and asynchronous active-low reset. The FSM, handshake and watchdog stay in the top module.

## Test plan
- Load at 0x100, memory acks 1 cycle after req with rdata 0xDEADBEEF, rd = 5, regwrite = 1, memtoreg = 1 → stall high for 2 cycles; MEM/WB gets readdata 0xDEADBEEF, rd 5; bubbles during the stall.
- Store with memread = memwrite = 1, addr 0x40, data 0x1234, ack after 3 wait cycles → dm_we = 1, dm_wdata = 0x1234 held stable, 5 stall cycles, wb_readdata 0.
- ALU op, then a load, then an ALU op → the first ALU op reaches MEM/WB with no stall; the load stalls; the second ALU op follows with no gap after DONE.
- branch = 1, zero = 1, adderout 0x80 → pcsrc = 1 and branch_target 0x80 in the same cycle; no stall.
- Reset asserted while in REQ → dm_req and all outputs 0 immediately; after release the state is IDLE and spurious acks are ignored.
- With MEM_TIMEOUT_EN and TIMEOUT = 4, no ack → DONE after 4 REQ cycles, dm_err = 1 sticky, wb_readdata 0. An ack coinciding with the limit → data captured and dm_err stays 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared types and constants for the memory-stage controller:
//   XLEN_DEF  - default datapath/address width
//   state_t   - controller FSM states (IDLE, REQ, DONE)
//   memwb_t   - packed MEM/WB register bundle
package mem_stage_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // MEM/WB contents. All-zero is the bubble encoding.
    typedef struct packed {
        logic [XLEN_DEF-1:0] readdata;
        logic [XLEN_DEF-1:0] alu_result;
        logic [4:0]          rd;
        logic                memtoreg;
        logic                regwrite;
    } memwb_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Data-memory request/acknowledge bus.
//   dm_req   controller -> memory  request held high while an access is open
//   dm_we    controller -> memory  1 = store, 0 = load
//   dm_addr  controller -> memory  access address (stable while dm_req)
//   dm_wdata controller -> memory  store data (stable while dm_req)
//   dm_ack   memory -> controller  one-cycle completion pulse
//   dm_rdata memory -> controller  load data, valid in the dm_ack cycle
// Handshake: the controller raises dm_req with stable we/addr/wdata and keeps
// them unchanged until it samples dm_ack = 1 at a rising edge; dm_req then
// drops on that same edge. dm_ack while dm_req is low has no effect.
interface mem_stage_ctrl_if
    import mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();

    logic            dm_req;
    logic            dm_we;
    logic [XLEN-1:0] dm_addr;
    logic [XLEN-1:0] dm_wdata;
    logic            dm_ack;
    logic [XLEN-1:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );

endinterface

// File: rtl/mem_stage_ctrl_memwb_reg.sv
// memwb_reg
// MEM/WB pipeline register with bubble insertion.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears the register
//   bubble 1 = load an all-zero bundle instead of d
//   d      next MEM/WB bundle
//   q      current MEM/WB bundle
module memwb_reg
    import mem_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory-stage controller of the 5-stage pipeline. Consumes EX/MEM, runs
// loads/stores over the dm bus, stalls upstream while an access is open,
// resolves branches and owns the MEM/WB register.
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   exm_*                EX/MEM register outputs (data and control)
//   dm                   data-memory bus (master side)
//   stall                hold PC, IF/ID, ID/EX, EX/MEM
//   pcsrc                branch taken / flush request
//   branch_target        branch target address
//   wb_*                 MEM/WB register contents
//   dm_err               sticky watchdog timeout flag
//   state_dbg            current FSM state
// Configuration macro: MEM_TIMEOUT_EN enables the REQ watchdog (TIMEOUT
// cycles). Without it REQ waits indefinitely and dm_err is tied low.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] exm_alu_result,
    input  logic [XLEN-1:0] exm_writedata,
    input  logic [XLEN-1:0] exm_adderout,
    input  logic [4:0]      exm_rd,
    input  logic            exm_branch,
    input  logic            exm_zero,
    input  logic            exm_memread,
    input  logic            exm_memtoreg,
    input  logic            exm_memwrite,
    input  logic            exm_regwrite,
    mem_stage_ctrl_if.master dm,
    output logic            stall,
    output logic            pcsrc,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] wb_readdata,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [4:0]      wb_rd,
    output logic            wb_memtoreg,
    output logic            wb_regwrite,
    output logic            dm_err,
    output state_t          state_dbg
);

    logic acc;
    logic is_load;

    // A set memwrite wins over memread, so "both" is a store.
    assign acc     = exm_memread | exm_memwrite;
    assign is_load = exm_memread & ~exm_memwrite;

    state_t state_q;
    state_t state_d;

    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rbuf_q;

    memwb_t memwb_d;
    memwb_t memwb_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          timeout_hit;
    logic          err_q;

    // Limit reached in the last allowed REQ cycle with no ack; an ack in
    // that same cycle takes priority.
    assign timeout_hit = (state_q == REQ) && !dm.dm_ack &&
                         (wd_cnt_q == CW'(TIMEOUT - 1));
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dm.dm_ack) begin
                    state_d = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign state_dbg = state_q;

    // ---------------- Bus registers ----------------
    // Address, data and direction are sampled when entering REQ; EX/MEM is
    // frozen by stall, so they stay stable until the ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && acc) begin
            req_q   <= 1'b1;
            we_q    <= exm_memwrite;
            addr_q  <= exm_alu_result;
            wdata_q <= exm_writedata;
        end else if (state_q == REQ && state_d == DONE) begin
            req_q   <= 1'b0;
        end
    end

    assign dm.dm_req   = req_q;
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;

    // Read buffer: only an ack seen in REQ is captured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbuf_q <= '0;
        end else if (state_q == REQ && dm.dm_ack) begin
            rbuf_q <= dm.dm_rdata;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timeout_hit) begin
            rbuf_q <= '0;
        end
`endif
    end

    // ---------------- Watchdog ----------------
`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
        end else if (state_q == REQ && state_d == REQ) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end else begin
            wd_cnt_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign dm_err = err_q;
`else
    assign dm_err = 1'b0;
`endif

    // ---------------- Combinational outputs ----------------
    // Gated by reset so every output reads 0 while reset is held.
    assign stall         = reset & acc & (state_q != DONE);
    assign pcsrc         = reset & exm_branch & exm_zero;
    assign branch_target = reset ? exm_adderout : '0;

    // ---------------- MEM/WB ----------------
    always_comb begin
        memwb_d            = '0;
        memwb_d.readdata   = is_load ? XLEN_DEF'(rbuf_q) : '0;
        memwb_d.alu_result = XLEN_DEF'(exm_alu_result);
        memwb_d.rd         = exm_rd;
        memwb_d.memtoreg   = exm_memtoreg;
        memwb_d.regwrite   = exm_regwrite;
    end

    memwb_reg u_memwb (
        .clk    (clk),
        .reset  (reset),
        .bubble (stall),
        .d      (memwb_d),
        .q      (memwb_q)
    );

    assign wb_readdata   = memwb_q.readdata[XLEN-1:0];
    assign wb_alu_result = memwb_q.alu_result[XLEN-1:0];
    assign wb_rd         = memwb_q.rd;
    assign wb_memtoreg   = memwb_q.memtoreg;
    assign wb_regwrite   = memwb_q.regwrite;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Bench for mem_stage_ctrl: directed vector table, reset-in-REQ sequence,
// watchdog sequences when MEM_TIMEOUT_EN is defined, then random instructions
// checked against an instruction-level model (stall count and MEM/WB result).
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    localparam int XLEN = 64;
    localparam int TO   = 4;
    localparam int W    = 2 * XLEN + 7;

    typedef struct {
        logic            branch;
        logic            zero;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            regwrite;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] adder;
        logic [XLEN-1:0] rdata;
        logic [4:0]      rd;
        int              wait_cyc;
        int              exp_stalls;
        logic [XLEN-1:0] exp_readdata;
        logic            exp_pcsrc;
    } vec_t;

    // ---------------- Clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [XLEN-1:0] exm_alu_result, exm_writedata, exm_adderout;
    logic [4:0]      exm_rd;
    logic            exm_branch, exm_zero, exm_memread, exm_memtoreg;
    logic            exm_memwrite, exm_regwrite;
    logic            stall, pcsrc, wb_memtoreg, wb_regwrite, dm_err;
    logic [XLEN-1:0] branch_target, wb_readdata, wb_alu_result;
    logic [4:0]      wb_rd;
    state_t          state_dbg;

    mem_stage_ctrl_if #(.XLEN(XLEN)) dm_bus ();

    mem_stage_ctrl #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .exm_alu_result (exm_alu_result),
        .exm_writedata  (exm_writedata),
        .exm_adderout   (exm_adderout),
        .exm_rd         (exm_rd),
        .exm_branch     (exm_branch),
        .exm_zero       (exm_zero),
        .exm_memread    (exm_memread),
        .exm_memtoreg   (exm_memtoreg),
        .exm_memwrite   (exm_memwrite),
        .exm_regwrite   (exm_regwrite),
        .dm             (dm_bus.master),
        .stall          (stall),
        .pcsrc          (pcsrc),
        .branch_target  (branch_target),
        .wb_readdata    (wb_readdata),
        .wb_alu_result  (wb_alu_result),
        .wb_rd          (wb_rd),
        .wb_memtoreg    (wb_memtoreg),
        .wb_regwrite    (wb_regwrite),
        .dm_err         (dm_err),
        .state_dbg      (state_dbg)
    );

    // ---------------- Scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_wb(input logic [XLEN-1:0] rdd, input logic [XLEN-1:0] alu,
                                             input logic [4:0] rd, input logic mtr, input logic rw);
        return {rdd, alu, rd, mtr, rw};
    endfunction

    function automatic vec_t mk(input logic br, input logic zr, input logic mr, input logic mw,
                                input logic mtr, input logic rw, input logic [XLEN-1:0] alu,
                                input logic [XLEN-1:0] wd, input logic [XLEN-1:0] ad,
                                input logic [XLEN-1:0] rdat, input logic [4:0] rd, input int wt,
                                input int es, input logic [XLEN-1:0] erd, input logic epc);
        vec_t v;
        v.branch = br; v.zero = zr; v.memread = mr; v.memwrite = mw;
        v.memtoreg = mtr; v.regwrite = rw; v.alu = alu; v.wdata = wd;
        v.adder = ad; v.rdata = rdat; v.rd = rd; v.wait_cyc = wt;
        v.exp_stalls = es; v.exp_readdata = erd; v.exp_pcsrc = epc;
        return v;
    endfunction

    // Instruction-level reference: an access costs one request cycle plus
    // (wait + 1) cycles with the request open; loads return the memory word.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        r.exp_stalls   = (v.memread | v.memwrite) ? v.wait_cyc + 2 : 0;
        r.exp_readdata = (v.memread && !v.memwrite) ? v.rdata : '0;
        r.exp_pcsrc    = v.branch & v.zero;
        return r;
    endfunction

    // ---------------- Memory responder ----------------
    int              mem_wait  = 0;
    logic [XLEN-1:0] mem_rdata = '0;
    logic            spur_ack  = 1'b0;
    logic [2*XLEN:0] exp_bus   = '0;
    int              resp_cnt  = 0;

    initial begin
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = '0;
        forever begin
            @(negedge clk);
            if (spur_ack) begin
                resp_cnt        = 0;
                dm_bus.dm_ack   = 1'b1;
                dm_bus.dm_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (dm_bus.dm_req) begin
                resp_cnt++;
                check("dm_bus_stable", {dm_bus.dm_we, dm_bus.dm_addr, dm_bus.dm_wdata}, exp_bus);
                if (resp_cnt == mem_wait + 1) begin
                    dm_bus.dm_ack   = 1'b1;
                    dm_bus.dm_rdata = mem_rdata;
                end else begin
                    dm_bus.dm_ack   = 1'b0;
                    dm_bus.dm_rdata = {$urandom, $urandom};
                end
            end else begin
                resp_cnt        = 0;
                dm_bus.dm_ack   = 1'b0;
                dm_bus.dm_rdata = '0;
            end
        end
    end

    // ---------------- Driver tasks ----------------
    task automatic drive(input vec_t v);
        exm_branch     = v.branch;
        exm_zero       = v.zero;
        exm_memread    = v.memread;
        exm_memwrite   = v.memwrite;
        exm_memtoreg   = v.memtoreg;
        exm_regwrite   = v.regwrite;
        exm_alu_result = v.alu;
        exm_writedata  = v.wdata;
        exm_adderout   = v.adder;
        exm_rd         = v.rd;
        mem_wait       = v.wait_cyc;
        mem_rdata      = v.rdata;
        exp_bus        = {v.memwrite, v.alu, v.wdata};
    endtask

    task automatic clear_inputs();
        drive(mk(0, 0, 0, 0, 0, 0, '0, '0, '0, '0, 5'd0, 0, 0, '0, 1'b0));
    endtask

    task automatic run_instr(input vec_t v);
        logic [W-1:0] e;
        @(negedge clk);
        drive(v);
        #1;
        check("pcsrc", pcsrc, v.exp_pcsrc);
        check("branch_target", branch_target, v.adder);
        for (int c = 0; c <= v.exp_stalls; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            check("stall", stall, (c < v.exp_stalls));
            if (c < v.exp_stalls) exp_q.push_back('0);
            else exp_q.push_back(pack_wb(v.exp_readdata, v.alu, v.rd, v.memtoreg, v.regwrite));
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check("memwb", {wb_readdata, wb_alu_result, wb_rd, wb_memtoreg, wb_regwrite}, e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dm_req"}, dm_bus.dm_req, 1'b0);
        check({tag, "_dm_bus"}, {dm_bus.dm_we, dm_bus.dm_addr, dm_bus.dm_wdata}, '0);
        check({tag, "_ctl"}, {stall, pcsrc, dm_err}, '0);
        check({tag, "_branch_target"}, branch_target, '0);
        check({tag, "_memwb"}, {wb_readdata, wb_alu_result, wb_rd, wb_memtoreg, wb_regwrite}, '0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    // ---------------- Safety timeout ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- Main test ----------------
    vec_t tbl[7];

    initial begin
        vec_t v;
        int   kind;

        tbl[0] = mk(0, 0, 0, 0, 0, 1, 64'h55, 64'h0, 64'h0, 64'h0, 5'd3, 0, 0, 64'h0, 0);
        tbl[1] = mk(0, 0, 1, 0, 1, 1, 64'h100, 64'h0, 64'h0, 64'hDEADBEEF, 5'd5, 0, 2, 64'hDEADBEEF, 0);
        tbl[2] = mk(0, 0, 0, 0, 0, 1, 64'h77, 64'h0, 64'h0, 64'h0, 5'd7, 0, 0, 64'h0, 0);
        tbl[3] = mk(0, 0, 1, 1, 0, 0, 64'h40, 64'h1234, 64'h0, 64'hFFFF, 5'd0, 3, 5, 64'h0, 0);
        tbl[4] = mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h80, 64'h0, 5'd0, 0, 0, 64'h0, 1);
        tbl[5] = mk(1, 0, 0, 0, 0, 0, 64'h9, 64'h0, 64'hC0, 64'h0, 5'd0, 0, 0, 64'h0, 0);
        tbl[6] = mk(0, 0, 1, 0, 1, 1, 64'h208, 64'h0, 64'h0, 64'hCAFE, 5'd31, 2, 4, 64'hCAFE, 0);

        // Reset state
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i]);
        end

        // Reset while a request is open
        v = mk(0, 0, 1, 0, 1, 1, 64'h200, 64'h0, 64'h0, 64'h1, 5'd9, 50, 0, 64'h0, 0);
        @(negedge clk);
        drive(v);
        @(negedge clk);
        #1;
        check("rst_req_open", {dm_bus.dm_req, state_dbg}, {1'b1, REQ});
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("rst_in_req");
        exp_q.delete();
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        reset    = 1'b1;
        spur_ack = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all_zero("spur_ack");
        end
        @(negedge clk);
        spur_ack = 1'b0;
        run_instr(tbl[1]);

`ifdef MEM_TIMEOUT_EN
        // Ack in the same cycle as the limit: data kept, no error
        run_instr(mk(0, 0, 1, 0, 1, 1, 64'h300, 64'h0, 64'h0, 64'h5A5A, 5'd4, TO - 1, TO + 1, 64'h5A5A, 0));
        check("err_ack_at_limit", dm_err, 1'b0);
        // No ack: forced completion after TO request cycles, zero data
        run_instr(mk(0, 0, 1, 0, 1, 1, 64'h308, 64'h0, 64'h0, 64'h7777, 5'd6, 100, TO + 1, 64'h0, 0));
        check("err_timeout", dm_err, 1'b1);
        run_instr(tbl[2]);
        check("err_sticky", dm_err, 1'b1);
`else
        check("err_tied_low", dm_err, 1'b0);
`endif

        // Random instructions against the reference model
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 3);
            v = mk(0, $urandom_range(0, 1), 0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, 5'($urandom_range(0, 31)), $urandom_range(0, 3), 0, '0, 0);
            case (kind)
                1: v.memread = 1'b1;
                2: begin
                    v.memwrite = 1'b1;
                    v.memread  = 1'($urandom_range(0, 1));
                end
                3: v.branch = 1'b1;
                default: ;
            endcase
            run_instr(model(v));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
